// File: rtl/generic_sync_fifo_env_ram.sv
// Single-clock FIFO with register-file storage, non-power-of-2 depth,
// programmable almost-full/empty thresholds and standard or FWFT read mode.
module generic_sync_fifo_env_ram #(
  parameter int unsigned PTR_WIDTH      = 4,
  parameter int unsigned NUM_OF_ENTRIES = 12,
  parameter int unsigned DAT_WIDTH      = 17,
  parameter int unsigned AFULL_TH       = 10,
  parameter int unsigned AEMPTY_TH      = 2,
  parameter int unsigned FWFT           = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic                 rd_op,
  input  logic                 err_clr,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 afull,
  output logic                 aempty,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic                 wr_full_err,
  output logic                 rd_empty_err
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_ADDR = PTR_WIDTH'(NUM_OF_ENTRIES - 1);

  logic [DAT_WIDTH-1:0] mem_q [NUM_OF_ENTRIES];

  logic [PTR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [PTR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  logic                 wr_full_err_q, wr_full_err_d;
  logic                 rd_empty_err_q, rd_empty_err_d;
  logic                 wr_acc, rd_acc;

  // Acceptance, pointer/count update and flag decode from the next count
  always_comb begin
    wr_acc         = wr_op && !full_q && !flush;
    rd_acc         = rd_op && !empty_q && !flush;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    cnt_d          = cnt_q;
    wr_full_err_d  = wr_full_err_q;
    rd_empty_err_d = rd_empty_err_q;

    if (flush) begin
      wr_addr_d = '0;
      rd_addr_d = '0;
      cnt_d     = '0;
    end else begin
      if (wr_acc) wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + PTR_WIDTH'(1);
      if (rd_acc) rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + PTR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    full_d   = (cnt_d == CNT_W'(NUM_OF_ENTRIES));
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= CNT_W'(AFULL_TH));
    aempty_d = (cnt_d <= CNT_W'(AEMPTY_TH));

    // Set takes priority over clear
    if (err_clr) begin
      wr_full_err_d  = 1'b0;
      rd_empty_err_d = 1'b0;
    end
    if (wr_op && full_q && !flush)  wr_full_err_d  = 1'b1;
    if (rd_op && empty_q && !flush) rd_empty_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      cnt_q          <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      afull_q        <= 1'b0;
      aempty_q       <= 1'b1;
      wr_full_err_q  <= 1'b0;
      rd_empty_err_q <= 1'b0;
    end else begin
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      cnt_q          <= cnt_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      afull_q        <= afull_d;
      aempty_q       <= aempty_d;
      wr_full_err_q  <= wr_full_err_d;
      rd_empty_err_q <= rd_empty_err_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr_q] <= wr_data;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DAT_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                 rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem_q[rd_addr_q];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is shown directly; rd_op acknowledges it
      assign rd_data  = mem_q[rd_addr_q];
      assign rd_valid = !empty_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign afull        = afull_q;
  assign aempty       = aempty_q;
  assign entry_used   = cnt_q;
  assign wr_full_err  = wr_full_err_q;
  assign rd_empty_err = rd_empty_err_q;

endmodule

// File: tb/tb_generic_sync_fifo_env_ram.sv
// Directed self-checking bench for generic_sync_fifo_env_ram, standard and FWFT instances.
module tb_generic_sync_fifo_env_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, wr_op, rd_op, err_clr;
  logic [16:0] wr_data;
  logic [16:0] rd_data;
  logic        rd_valid, full, empty, afull, aempty, wr_full_err, rd_empty_err;
  logic [4:0]  entry_used;

  logic        f_flush, f_wr_op, f_rd_op, f_err_clr;
  logic [16:0] f_wr_data;
  logic [16:0] f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_wr_full_err, f_rd_empty_err;
  logic [4:0]  f_entry_used;

  int n_tests = 0;
  int n_fail  = 0;

  generic_sync_fifo_env_ram dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_op(wr_op), .wr_data(wr_data),
    .rd_op(rd_op), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty), .entry_used(entry_used),
    .wr_full_err(wr_full_err), .rd_empty_err(rd_empty_err)
  );

  generic_sync_fifo_env_ram #(.FWFT(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .flush(f_flush), .wr_op(f_wr_op), .wr_data(f_wr_data),
    .rd_op(f_rd_op), .err_clr(f_err_clr), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .full(f_full), .empty(f_empty), .afull(f_afull), .aempty(f_aempty), .entry_used(f_entry_used),
    .wr_full_err(f_wr_full_err), .rd_empty_err(f_rd_empty_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush = 0; wr_op = 0; rd_op = 0; err_clr = 0; wr_data = '0;
    f_flush = 0; f_wr_op = 0; f_rd_op = 0; f_err_clr = 0; f_wr_data = '0;
    #12;
    n_tests++; if (entry_used !== 5'd0) begin n_fail++; $display("FAIL reset_used: got %0d expected 0", entry_used); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_tests++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", afull); end
    n_tests++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", aempty); end
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 17'h0) begin n_fail++; $display("FAIL reset_rd: got valid=%b data=%h expected 0/0", rd_valid, rd_data); end
    n_tests++; if (wr_full_err !== 1'b0 || rd_empty_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", wr_full_err, rd_empty_err); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 12; i++) begin
      wr_op = 1; wr_data = 17'(i);
      cyc();
      n_tests++; if (entry_used !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_used[%0d]: got %0d expected %0d", i, entry_used, i + 1); end
      n_tests++; if (afull !== (i + 1 >= 10)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, afull, (i + 1 >= 10)); end
      n_tests++; if (full !== (i == 11)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 11)); end
    end
    wr_op = 0;
    for (int k = 0; k < 12; k++) begin
      rd_op = 1;
      cyc();
      n_tests++; if (rd_data !== 17'(k) || rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_data[%0d]: got %h/%b expected %h/1", k, rd_data, rd_valid, k); end
      n_tests++; if (entry_used !== 5'(11 - k)) begin n_fail++; $display("FAIL drain_used[%0d]: got %0d expected %0d", k, entry_used, 11 - k); end
      n_tests++; if (aempty !== (11 - k <= 2)) begin n_fail++; $display("FAIL drain_aempty[%0d]: got %b expected %b", k, aempty, (11 - k <= 2)); end
    end
    rd_op = 0;
    cyc();
    n_tests++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_end: got valid=%b empty=%b expected 0/1", rd_valid, empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      wr_op = 1; wr_data = 17'(32'h100 + i);
      cyc();
    end
    for (int j = 0; j < 30; j++) begin
      wr_op = 1; rd_op = 1; wr_data = 17'(32'h105 + j);
      cyc();
      n_tests++; if (rd_data !== 17'(32'h100 + j)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", j, rd_data, 32'h100 + j); end
      n_tests++; if (entry_used !== 5'd5) begin n_fail++; $display("FAIL wrap_used[%0d]: got %0d expected 5", j, entry_used); end
      n_tests++; if (dut.wr_addr_q >= 4'd12 || dut.rd_addr_q >= 4'd12) begin n_fail++; $display("FAIL wrap_ptr[%0d]: got wr=%0d rd=%0d expected <12", j, dut.wr_addr_q, dut.rd_addr_q); end
    end
    wr_op = 0;
    for (int k = 0; k < 5; k++) begin
      rd_op = 1;
      cyc();
      n_tests++; if (rd_data !== 17'(32'h11E + k)) begin n_fail++; $display("FAIL wrap_tail[%0d]: got %h expected %h", k, rd_data, 32'h11E + k); end
    end
    rd_op = 0;
    cyc();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) begin
      wr_op = 1; wr_data = 17'(32'h50 + i);
      cyc();
    end
    wr_op = 1; rd_op = 1; wr_data = 17'h1FFFF;
    cyc();
    n_tests++; if (entry_used !== 5'd11) begin n_fail++; $display("FAIL ovf_used: got %0d expected 11", entry_used); end
    n_tests++; if (wr_full_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", wr_full_err); end
    n_tests++; if (rd_data !== 17'h50 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_rd: got %h/%b expected 50/1", rd_data, rd_valid); end
    wr_op = 0;
    for (int k = 0; k < 11; k++) begin
      cyc();
      n_tests++; if (rd_data !== 17'(32'h51 + k)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h expected %h", k, rd_data, 32'h51 + k); end
    end
    cyc();
    n_tests++; if (rd_empty_err !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL udf: got err=%b valid=%b expected 1/0", rd_empty_err, rd_valid); end
    n_tests++; if (entry_used !== 5'd0) begin n_fail++; $display("FAIL udf_used: got %0d expected 0", entry_used); end
    rd_op = 0; err_clr = 1;
    cyc();
    n_tests++; if (wr_full_err !== 1'b0 || rd_empty_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b%b expected 00", wr_full_err, rd_empty_err); end
    rd_op = 1;
    cyc();
    n_tests++; if (rd_empty_err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b expected 1", rd_empty_err); end
    rd_op = 0; err_clr = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      wr_op = 1; wr_data = 17'(32'h70 + i);
      cyc();
    end
    n_tests++; if (entry_used !== 5'd7) begin n_fail++; $display("FAIL flush_pre: got %0d expected 7", entry_used); end
    rd_op = 1; wr_data = 17'h77;
    cyc();
    flush = 1; wr_data = 17'h1234;
    cyc();
    n_tests++; if (entry_used !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_cnt: got used=%0d empty=%b expected 0/1", entry_used, empty); end
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 17'h70) begin n_fail++; $display("FAIL flush_rd: got %b/%h expected 0/70", rd_valid, rd_data); end
    n_tests++; if (rd_empty_err !== 1'b1 || wr_full_err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b%b expected 01", wr_full_err, rd_empty_err); end
    flush = 0; rd_op = 0; wr_op = 1; wr_data = 17'h0AA;
    cyc();
    n_tests++; if (entry_used !== 5'd1) begin n_fail++; $display("FAIL flush_post_used: got %0d expected 1", entry_used); end
    wr_op = 0; rd_op = 1;
    cyc();
    n_tests++; if (rd_data !== 17'h0AA) begin n_fail++; $display("FAIL flush_post_rd: got %h expected 0aa", rd_data); end
    rd_op = 0;
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      wr_op = 1; wr_data = 17'(32'h300 + i);
      cyc();
    end
    rd_op = 1;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (entry_used !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1) begin n_fail++; $display("FAIL arst_cnt: got used=%0d empty=%b aempty=%b expected 0/1/1", entry_used, empty, aempty); end
    n_tests++; if (full !== 1'b0 || afull !== 1'b0) begin n_fail++; $display("FAIL arst_full: got %b%b expected 00", full, afull); end
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 17'h0) begin n_fail++; $display("FAIL arst_rd: got %b/%h expected 0/0", rd_valid, rd_data); end
    n_tests++; if (rd_empty_err !== 1'b0 || wr_full_err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b%b expected 00", wr_full_err, rd_empty_err); end
    wr_op = 0; rd_op = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_fwft();
    f_wr_op = 1; f_wr_data = 17'h1A5;
    cyc();
    f_wr_op = 0;
    n_tests++; if (f_rd_data !== 17'h1A5 || f_rd_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_show: got %h/%b expected 1a5/1", f_rd_data, f_rd_valid); end
    cyc();
    n_tests++; if (f_rd_data !== 17'h1A5 || f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_hold: got %h/%b expected 1a5/0", f_rd_data, f_empty); end
    f_rd_op = 1;
    cyc();
    f_rd_op = 0;
    n_tests++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_ack: got empty=%b valid=%b expected 1/0", f_empty, f_rd_valid); end
    f_wr_op = 1; f_wr_data = 17'h011;
    cyc();
    f_wr_data = 17'h022;
    cyc();
    f_wr_op = 0;
    n_tests++; if (f_rd_data !== 17'h011 || f_entry_used !== 5'd2) begin n_fail++; $display("FAIL fwft_head: got %h/%0d expected 011/2", f_rd_data, f_entry_used); end
    f_rd_op = 1;
    cyc();
    f_rd_op = 0;
    n_tests++; if (f_rd_data !== 17'h022 || f_rd_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_next: got %h/%b expected 022/1", f_rd_data, f_rd_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow();
    test_flush();
    test_reset_mid_burst();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/generic_sync_fifo_env_ram.md
# generic_sync_fifo_env_ram

Single-clock FIFO with integrated register-file storage, generalising the two-clock FIFO environment for same-domain buffering. It supports non-power-of-2 depth, programmable almost-full and almost-empty thresholds, and a selectable standard or first-word-fall-through (FWFT) read mode. It also provides synchronous flush and sticky overflow/underflow errors with clear. It sits between same-clock producer/consumer blocks in the SoC building-block library.

## Interface
- PTR_WIDTH, 4: address width.
- NUM_OF_ENTRIES, 12: depth; legal range 2..2^PTR_WIDTH, need not be a power of 2.
- DAT_WIDTH, 17: data width.
- AFULL_TH, 10: rd_afull threshold; legal range 1..NUM_OF_ENTRIES.
- AEMPTY_TH, 2: rd_aempty threshold; legal range 0..NUM_OF_ENTRIES-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_op  in  1  write request.
- wr_data  in  DAT_WIDTH  write data.
- rd_op  in  1  read request.
- err_clr  in  1  clears the sticky error flags.
- rd_data  out  DAT_WIDTH  read data.
- rd_valid  out  1  rd_data holds valid data.
- full  out  1  count == NUM_OF_ENTRIES.
- empty  out  1  count == 0.
- afull  out  1  count >= AFULL_TH.
- aempty  out  1  count <= AEMPTY_TH.
- entry_used  out  PTR_WIDTH+1  current count.
- wr_full_err  out  1  sticky overflow flag.
- rd_empty_err  out  1  sticky underflow flag.

## Operation
- Storage: NUM_OF_ENTRIES x DAT_WIDTH array; the array is not reset.
- Write acceptance: a write is accepted iff wr_op && !full && !flush. It writes mem[wr_addr] and advances wr_addr.
- Read acceptance: a read is accepted iff rd_op && !empty && !flush. It advances rd_addr.
- Full and empty come from the registered count. A write while full is rejected even if a read occurs in the same cycle. A read while empty is rejected even if a write occurs in the same cycle.
- Pointer wrap: wr_addr and rd_addr count 0..NUM_OF_ENTRIES-1, then wrap to 0. They never reach values >= NUM_OF_ENTRIES.
- Count update (entry_used):
  - +1 on write only.
  - -1 on read only.
  - unchanged when both or neither occur.
  - The count never exceeds NUM_OF_ENTRIES and never goes below 0.
- Status flags: full, empty, afull and aempty are decoded only from the count register.
- Flush: sets pointers and count to 0 and has priority over rd_op/wr_op in the same cycle. In standard mode flush also clears rd_valid. Flush does not clear the error flags or rd_data.
- Errors:
  - wr_full_err sets on wr_op && full && !flush.
  - rd_empty_err sets on rd_op && empty && !flush.
  - Both flags stay set until err_clr. If set and clear occur in the same cycle, set wins.
- Standard mode (FWFT=0):
  - rd_data is a register loaded with mem[rd_addr] on an accepted read.
  - It holds its value otherwise.
  - rd_valid is a one-cycle pulse in the cycle after an accepted read.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_addr] (combinational array read); rd_valid = !empty.
  - rd_op acknowledges the displayed word.
  - rd_data is don't-care while empty.
- Reset values:
  - pointers 0, entry_used 0.
  - empty 1, full 0, afull 0, aempty 1.
  - rd_valid 0, rd_data 0 (standard mode).
  - both error flags 0.

## Timing
- Write to visibility: a write accepted at edge N is counted at edge N. empty deasserts, and in FWFT mode rd_data shows the word, in cycle N+1.
- Read latency, standard mode: for rd_op sampled at edge N, rd_data and rd_valid are valid in cycle N+1.
- Read latency, FWFT mode: zero; data is present while !empty, and the next word is shown after the edge that accepts rd_op.
- Flags: all status flags update one cycle after the accepted operation, with no lookahead.
- Throughput: one write and one read may both be accepted every cycle when 0 < count < NUM_OF_ENTRIES.
- Reset: reset_n assertion takes effect immediately, mid-operation, with no clock required.

## Test plan
- Fill and drain (defaults): write 0x00..0x0B in 12 cycles, no reads.
  - full=1 and entry_used=12 after the 12th edge; afull rises after the 10th write.
  - Read 12 in standard mode -> rd_data 0x00..0x0B, each one cycle after its rd_op.
  - Then empty=1, and aempty=1 once count <= 2.
- Wrap-around: run 30 cycles of simultaneous rd/wr with count=5 in a 12-deep FIFO.
  - entry_used stays 5, data order is preserved, and pointers wrap 11 -> 0 with no value >= 12.
- Overflow/underflow:
  - wr_op while full with rd_op in the same cycle -> the write is dropped, wr_full_err=1, entry_used=11.
  - rd_op while empty -> rd_empty_err=1, rd_valid stays 0.
  - err_clr -> both flags return to 0.
  - err_clr with a simultaneous violation -> the flag stays 1.
- FWFT=1: write 0x1A5 to an empty FIFO.
  - rd_data=0x1A5 and rd_valid=1 in the next cycle without rd_op.
  - Then rd_op -> empty=1 the cycle after.
- Flush and reset: with count=7, assert flush together with wr_op and rd_op.
  - entry_used=0, empty=1, the write is discarded, and the error flags are unchanged.
  - Assert reset_n low mid-burst -> all outputs reach their reset values asynchronously.
